// File: rtl/fm_sb_pkg.sv
// fm_sb_pkg: shared state type, playback-mode codes and default widths for the FM spy-buffer channel
package fm_sb_pkg;
  typedef enum logic [1:0] {CAPTURE, FROZEN, PLAYBACK, INIT} sb_state_e;
  localparam int PB_PASS = 0;
  localparam int PB_ONCE = 1;
  localparam int PB_LOOP = 2;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_PTR_WIDTH = 10;
  localparam int DEF_PB_MODE_WIDTH = 2;
endpackage

// File: rtl/fm_sb_dpram.sv
// fm_sb_dpram: dual-port RAM, port A read/write for the channel, port B read-only for AXI, 1-cycle read latency
module fm_sb_dpram
  import fm_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_PTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  output logic [DATA_WIDTH-1:0] b_rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  // write on port A, registered reads on both ports
  always_ff @(posedge clk) begin
    if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
    a_rdata_o <= mem_q[a_addr_i];
    b_rdata_o <= mem_q[b_addr_i];
  end
endmodule

// File: rtl/fm_sb_channel.sv
// fm_sb_channel: spy-buffer channel (record, freeze, playback, zero-fill); FM_SB_WORD_CNT_EN enables the word counter
module fm_sb_channel
  import fm_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PTR_WIDTH = DEF_PTR_WIDTH,
  parameter int PB_MODE_WIDTH = DEF_PB_MODE_WIDTH
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset,
  input  logic                     sb_reset,
  input  logic                     freeze,
  input  logic [PB_MODE_WIDTH-1:0] playback_mode,
  input  logic                     init_spy_mem,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic [PTR_WIDTH-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [PTR_WIDTH-1:0]     wr_ptr,
  output logic                     wrapped,
  output logic                     busy,
  output logic                     pb_done,
  output logic [31:0]              word_cnt
);
  sb_state_e state_q, state_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, addr_q, addr_d;
  logic wrapped_q, wrapped_d, done_q, done_d, out_valid_q, out_valid_d;
  logic pb_done_q, pb_done_d, pb_sel_q, pb_sel_d, init_q;
  logic [DATA_WIDTH-1:0] pass_q, a_rdata;
  logic rst, init_rise, mode_once, mode_loop, mode_play, can_play, at_last, init_last, cap_wr, abort;
  logic [PTR_WIDTH-1:0] start;
  assign rst = axi_reset | sb_reset;
  assign init_rise = init_spy_mem & ~init_q;
  assign mode_once = playback_mode == PB_MODE_WIDTH'(PB_ONCE);
  assign mode_loop = playback_mode == PB_MODE_WIDTH'(PB_LOOP);
  assign mode_play = mode_once | mode_loop;
  assign start = wrapped_q ? wr_ptr_q : '0;
  assign at_last = addr_q == wr_ptr_q - 1'b1;
  assign init_last = addr_q == '1;
  assign abort = ~freeze | ~mode_play;
  assign can_play = (wrapped_q | (wr_ptr_q != '0)) & (mode_loop | (mode_once & ~done_q));
  assign cap_wr = (state_q == CAPTURE) & in_valid & ~freeze & ~init_rise;
  // next-state, pointer and output-qualifier logic
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wr_ptr_d = cap_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    wrapped_d = wrapped_q | (cap_wr & (wr_ptr_q == '1));
    done_d = done_q & freeze & mode_once;
    out_valid_d = in_valid & ((state_q == CAPTURE) | ((state_q == FROZEN) & ~mode_play));
    pb_sel_d = 1'b0;
    pb_done_d = 1'b0;
    case (state_q)
      CAPTURE: begin
        addr_d = '0;
        state_d = init_rise ? INIT : freeze ? FROZEN : CAPTURE;
      end
      FROZEN: begin
        addr_d = init_rise ? '0 : start;
        state_d = init_rise ? INIT : ~freeze ? CAPTURE : can_play ? PLAYBACK : FROZEN;
      end
      PLAYBACK: begin
        out_valid_d = ~abort;
        pb_sel_d = ~abort;
        pb_done_d = ~abort & mode_once & at_last;
        done_d = pb_done_d;
        addr_d = at_last ? start : addr_q + 1'b1;
        state_d = ~freeze ? CAPTURE : (~mode_play | (mode_once & at_last)) ? FROZEN : PLAYBACK;
      end
      INIT: begin
        addr_d = addr_q + 1'b1;
        wr_ptr_d = init_last ? '0 : wr_ptr_q;
        wrapped_d = init_last ? 1'b0 : wrapped_q;
        state_d = init_last ? (freeze ? FROZEN : CAPTURE) : INIT;
      end
    endcase
  end
  // state and output registers; the init edge detector runs through reset
  always_ff @(posedge axi_clk) begin
    init_q <= init_spy_mem;
    if (rst) begin
      state_q <= CAPTURE;
      wr_ptr_q <= '0;
      wrapped_q <= 1'b0;
      addr_q <= '0;
      done_q <= 1'b0;
      out_valid_q <= 1'b0;
      pb_done_q <= 1'b0;
      pb_sel_q <= 1'b0;
      pass_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      wrapped_q <= wrapped_d;
      addr_q <= addr_d;
      done_q <= done_d;
      out_valid_q <= out_valid_d;
      pb_done_q <= pb_done_d;
      pb_sel_q <= pb_sel_d;
      pass_q <= in_data;
    end
  end
  fm_sb_dpram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(PTR_WIDTH)) u_ram (
    .clk      (axi_clk),
    .a_we_i   (~rst & (cap_wr | (state_q == INIT))),
    .a_addr_i (state_q == CAPTURE ? wr_ptr_q : addr_q),
    .a_wdata_i(state_q == INIT ? '0 : in_data),
    .a_rdata_o(a_rdata),
    .b_addr_i (rd_addr),
    .b_rdata_o(rd_data)
  );
`ifdef FM_SB_WORD_CNT_EN
  logic [31:0] cnt_q;
  // saturating count of captured words, cleared on reset and zero-fill completion
  always_ff @(posedge axi_clk) begin
    if (rst || (state_q == INIT && init_last)) cnt_q <= '0;
    else if (cap_wr && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end
  assign word_cnt = cnt_q;
`else
  assign word_cnt = '0;
`endif
  assign out_data = pb_sel_q ? a_rdata : pass_q;
  assign out_valid = out_valid_q;
  assign pb_done = pb_done_q;
  assign wr_ptr = wr_ptr_q;
  assign wrapped = wrapped_q;
  assign busy = (state_q == INIT) | (state_q == PLAYBACK);
endmodule

// File: tb/tb_fm_sb_channel.sv
// tb_fm_sb_channel: scoreboard bench for the spy-buffer channel against a history-queue reference model
module tb_fm_sb_channel;
  localparam int DW = 32;
  localparam int PW = 4;
  localparam int DEPTH = 16;
`ifdef FM_SB_WORD_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic axi_clk = 1'b0;
  logic axi_reset, sb_reset, freeze, init_spy_mem, in_valid, out_valid, wrapped, busy, pb_done;
  logic [1:0] playback_mode;
  logic [DW-1:0] in_data, out_data, rd_data;
  logic [PW-1:0] rd_addr, wr_ptr;
  logic [31:0] word_cnt;
  typedef struct {logic [DW-1:0] d; logic done;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] hist[$];
  int total = 0;
  int errors = 0;
  int checks = 0;
  int popped = 0;
  int base, c;
  always #5 axi_clk = ~axi_clk;
  fm_sb_channel #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .PB_MODE_WIDTH(2)) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset), .sb_reset(sb_reset), .freeze(freeze),
    .playback_mode(playback_mode), .init_spy_mem(init_spy_mem), .in_data(in_data),
    .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_ptr(wr_ptr), .wrapped(wrapped), .busy(busy), .pb_done(pb_done),
    .word_cnt(word_cnt)
  );
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge axi_clk);
    #1;
  endtask
  task automatic model_clear;
    total = 0;
    hist.delete();
  endtask
  task automatic put(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data = d;
    exp_q.push_back('{d, 1'b0});
    mem_m[total % DEPTH] = d;
    hist.push_back(d);
    if (hist.size() > DEPTH) void'(hist.pop_front());
    total++;
    tick;
    in_valid = 1'b0;
  endtask
  task automatic put_gappy(input int n, input logic [DW-1:0] b, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        in_data = $urandom;
        tick;
      end
      put(rnd ? DW'($urandom) : b + DW'(i));
    end
  endtask
  task automatic drain(input string n);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick;
    chk(n, exp_q.size(), 0);
  endtask
  task automatic check_state(input string n);
    chk({n, "_wr_ptr"}, wr_ptr, total % DEPTH);
    chk({n, "_wrapped"}, wrapped, total >= DEPTH);
    chk({n, "_word_cnt"}, word_cnt, CNT_EN ? total : 0);
  endtask
  task automatic readback(input string n);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = PW'(a);
      tick;
      chk(n, rd_data, mem_m[a]);
    end
  endtask
  always @(negedge axi_clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected got=%0h exp=none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("pb_done", pb_done, e.done);
        popped++;
      end
    end else if (pb_done) chk("pb_done_idle", pb_done, 0);
  end
  initial begin
    #300000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  initial begin
    axi_reset = 1'b1; sb_reset = 1'b0; freeze = 1'b0; init_spy_mem = 1'b0;
    in_valid = 1'b0; in_data = '0; playback_mode = 2'd0; rd_addr = '0;
    repeat (3) tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pb_done", pb_done, 0);
    check_state("rst");
    axi_reset = 1'b0;
    for (int i = 0; i < 5; i++) put(DW'(32'hA0 + i));
    tick;
    drain("pass_drain");
    check_state("pass");
    axi_reset = 1'b1;
    tick;
    axi_reset = 1'b0;
    model_clear();
    put_gappy(20, '0, 1'b0);
    tick;
    drain("wrap_drain");
    check_state("wrap");
    rd_addr = 4'd3;
    tick;
    chk("rd_addr3", rd_data, 19);
    rd_addr = 4'd4;
    tick;
    chk("rd_addr4", rd_data, 4);
    readback("rd_wrap");
    freeze = 1'b1;
    repeat (2) tick;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('{hist[i], i == DEPTH - 1});
    playback_mode = 2'd1;
    drain("once_drain");
    repeat (3) tick;
    chk("once_busy", busy, 0);
    chk("once_out_valid", out_valid, 0);
    check_state("once");
    base = popped;
    for (int i = 0; i < 40; i++) exp_q.push_back('{hist[i % DEPTH], 1'b0});
    playback_mode = 2'd2;
    for (int i = 0; i < 200 && popped < base + 20; i++) tick;
    chk("loop_reach", popped >= base + 20, 1);
    playback_mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
    end
    chk("abort_popped", popped - base, 21);
    exp_q.delete();
    freeze = 1'b0;
    tick;
    chk("resume_wr_ptr", wr_ptr, 4);
    put_gappy(6, '0, 1'b1);
    tick;
    drain("resume_drain");
    check_state("resume");
    readback("rd_resume");
    freeze = 1'b1;
    tick;
    init_spy_mem = 1'b1;
    tick;
    c = 0;
    while (busy && c < 40) begin
      c++;
      tick;
    end
    chk("init_busy_cycles", c, DEPTH);
    for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
    model_clear();
    tick;
    check_state("init");
    chk("init_out_valid", out_valid, 0);
    readback("rd_init");
    init_spy_mem = 1'b0;
    axi_reset = 1'b1;
    tick;
    axi_reset = 1'b0;
    model_clear();
    playback_mode = 2'd1;
    repeat (4) tick;
    chk("empty_busy", busy, 0);
    chk("empty_out_valid", out_valid, 0);
    check_state("empty");
    playback_mode = 2'd0;
    init_spy_mem = 1'b1;
    tick;
    repeat (5) tick;
    chk("midinit_busy", busy, 1);
    sb_reset = 1'b1;
    tick;
    sb_reset = 1'b0;
    chk("sbrst_busy", busy, 0);
    chk("sbrst_out_valid", out_valid, 0);
    model_clear();
    check_state("sbrst");
    freeze = 1'b0;
    repeat (2) tick;
    put_gappy(3, '0, 1'b1);
    tick;
    drain("final_drain");
    check_state("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
